// File: rtl/seq_check_ctrl.sv
// seq_check_ctrl: programmable serial-pattern detection controller.
// Holds the pattern configuration, arms/disarms a detection run, counts
// matches against a threshold and enforces an observation window.
// Run sequence: IDLE -> ARMED -> DONE/TIMEOUT -> IDLE.
// Optional build macro SEQ_CHECK_NOOVERLAP_EN: every match clears the
// history and fill counter (non-overlapping detection). Left undefined,
// history is kept across matches and overlapping matches count.
module seq_check_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_threshold,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in_sig,
  output logic             busy,
  output logic             pattern_found,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             timeout,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);

  state_t           r_state, w_nstate;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_thr;
  logic [WIN_W-1:0] r_win_lim;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pf, r_done, r_to;

  logic [LEN_W-1:0] w_len_eff;
  logic [CNT_W-1:0] w_thr_eff;
  logic             w_cfg_valid;
  logic             w_arm;
  logic [PAT_W-1:0] w_hist_shift;
  logic [LEN_W-1:0] w_fill_inc;
  logic [PAT_W-1:0] w_mask;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_thr_hit;
  logic [WIN_W-1:0] w_win_inc;
  logic             w_win_exp;
  logic             w_pf_n, w_done_n, w_to_n;

  // A cfg_load coinciding with start must configure the run it starts,
  // so validity is judged on the incoming values in that case.
  assign w_len_eff   = cfg_load ? cfg_len : r_len;
  assign w_thr_eff   = cfg_load ? cfg_threshold : r_thr;
  assign w_cfg_valid = (w_len_eff != '0) && (w_len_eff <= PAT_LEN) && (w_thr_eff != '0);
  assign w_arm       = (r_state == S_IDLE) && start && !abort && w_cfg_valid;

  assign w_hist_shift = {r_hist[PAT_W-2:0], in_sig};
  assign w_fill_inc   = (r_fill == PAT_LEN) ? r_fill : r_fill + 1'b1;
  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_win_inc    = r_win + 1'b1;

  // Mask selecting the low r_len bits of history and pattern.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) w_mask[i] = (i < int'(r_len));
  end

  assign w_match   = in_valid && (w_fill_inc >= r_len) &&
                     ((w_hist_shift & w_mask) == (r_pat & w_mask));
  assign w_thr_hit = w_match && (w_cnt_inc == r_thr);
  assign w_win_exp = (r_win_lim != '0) && (w_win_inc == r_win_lim);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nstate;
  end

  // Next-state and next pulse values; abort wins, then threshold, then window.
  always_comb begin
    w_nstate = r_state;
    w_pf_n   = 1'b0;
    w_done_n = 1'b0;
    w_to_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arm) w_nstate = S_ARMED;
      end
      S_ARMED: begin
        if (abort) begin
          w_nstate = S_IDLE;
        end else if (w_thr_hit) begin
          w_nstate = S_DONE;
          w_pf_n   = 1'b1;
          w_done_n = 1'b1;
        end else if (w_win_exp) begin
          w_nstate = S_TIMEOUT;
          w_to_n   = 1'b1;
          w_pf_n   = w_match;
        end else begin
          w_pf_n   = w_match;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pf   <= 1'b0;
      r_done <= 1'b0;
      r_to   <= 1'b0;
    end else begin
      r_pf   <= w_pf_n;
      r_done <= w_done_n;
      r_to   <= w_to_n;
    end
  end

  // Configuration latch; only accepted while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat     <= '0;
      r_len     <= '0;
      r_thr     <= '0;
      r_win_lim <= '0;
    end else if (r_state == S_IDLE && cfg_load) begin
      r_pat     <= cfg_pattern;
      r_len     <= cfg_len;
      r_thr     <= cfg_threshold;
      r_win_lim <= cfg_window;
    end
  end

  // Run datapath: history, fill, window and match counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_win  <= '0;
      r_cnt  <= '0;
    end else if (w_arm) begin
      r_hist <= '0;
      r_fill <= '0;
      r_win  <= '0;
      r_cnt  <= '0;
    end else if (r_state == S_ARMED && !abort) begin
      r_win <= w_win_inc;
      if (in_valid) begin
`ifdef SEQ_CHECK_NOOVERLAP_EN
        if (w_match) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_hist_shift;
          r_fill <= w_fill_inc;
        end
`else
        r_hist <= w_hist_shift;
        r_fill <= w_fill_inc;
`endif
      end
      if (w_match) r_cnt <= w_cnt_inc;
    end
  end

  assign busy          = (r_state == S_ARMED);
  assign pattern_found = r_pf;
  assign done          = r_done;
  assign timeout       = r_to;
  assign match_count   = r_cnt;
  assign state         = r_state;

endmodule

// File: tb/tb_seq_check_ctrl.sv
// Scoreboard bench for seq_check_ctrl: the driver pushes the expected pulse
// record before issuing the completing stimulus; a negedge monitor pops and
// compares whenever pattern_found/done/timeout is presented.
module tb_seq_check_ctrl;
  localparam int PAT_W = 8, LEN_W = 4, CNT_W = 8, WIN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_load, start, abort, in_valid, in_sig;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_threshold;
  logic [WIN_W-1:0] cfg_window;
  logic             busy, pattern_found, done, timeout;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       state;

  typedef struct packed {
    logic       pf;
    logic       dn;
    logic       to;
    logic [7:0] cnt;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  seq_check_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_threshold(cfg_threshold), .cfg_window(cfg_window),
    .start(start), .abort(abort), .in_valid(in_valid), .in_sig(in_sig),
    .busy(busy), .pattern_found(pattern_found), .match_count(match_count),
    .done(done), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic pf, input logic dn, input logic to,
                      input logic [7:0] cnt, input logic [1:0] st);
    exp_t e;
    e.pf = pf; e.dn = dn; e.to = to; e.cnt = cnt; e.st = st;
    q.push_back(e);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len,
                     input logic [7:0] thr, input logic [15:0] win);
    cfg_pattern = pat; cfg_len = len; cfg_threshold = thr; cfg_window = win;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    in_valid = 1'b1; in_sig = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    step();
  endtask

  // Monitor: any presented pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && (pattern_found || done || timeout)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got pf=%0b done=%0b timeout=%0b expected no pulse",
                 pattern_found, done, timeout);
      end else begin
        mon_e = q.pop_front();
        chk("mon_pattern_found", 32'(pattern_found), 32'(mon_e.pf));
        chk("mon_done",          32'(done),          32'(mon_e.dn));
        chk("mon_timeout",       32'(timeout),       32'(mon_e.to));
        chk("mon_match_count",   32'(match_count),   32'(mon_e.cnt));
        chk("mon_state",         32'(state),         32'(mon_e.st));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; cfg_load = 0; start = 0; abort = 0; in_valid = 0; in_sig = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_threshold = '0; cfg_window = '0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pf", 32'(pattern_found), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_count", 32'(match_count), 0);
    step();
    rst = 1'b1;
    step();

    // Basic 110
    cfg(8'b110, 4'd3, 8'd1, 16'd0);
    start_run();
    chk("basic_busy", 32'(busy), 1);
    chk("basic_armed", 32'(state), 1);
    bit_in(1); bit_in(1);
    push(1, 1, 0, 8'd1, 2'd2);
    bit_in(0);
    chk("basic_state_done", 32'(state), 2);
    chk("basic_busy_done", 32'(busy), 0);
    step();
    chk("basic_state_idle", 32'(state), 0);
    chk("basic_count_hold", 32'(match_count), 1);

    // Overlap 101, threshold 2
    cfg(8'b101, 4'd3, 8'd2, 16'd0);
    start_run();
    bit_in(1); bit_in(0);
    push(1, 0, 0, 8'd1, 2'd1);
    bit_in(1);
    bit_in(0);
`ifdef SEQ_CHECK_NOOVERLAP_EN
    bit_in(1);
    chk("noovl_busy", 32'(busy), 1);
    chk("noovl_count", 32'(match_count), 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("noovl_abort_idle", 32'(state), 0);
`else
    push(1, 1, 0, 8'd2, 2'd2);
    bit_in(1);
    chk("ovl_state_done", 32'(state), 2);
    chk("ovl_count", 32'(match_count), 2);
    step();
`endif

    // Timeout after 10 ARMED cycles
    cfg(8'b110, 4'd3, 8'd1, 16'd10);
    start_run();
    chk("to_count_cleared", 32'(match_count), 0);
    push(0, 0, 1, 8'd0, 2'd3);
    for (int i = 0; i < 10; i++) bit_in(0);
    chk("to_state", 32'(state), 3);
    step();
    chk("to_idle", 32'(state), 0);

    // in_valid gaps; window 6 expires on the completing bit -> DONE wins
    cfg(8'b110, 4'd3, 8'd1, 16'd6);
    start_run();
    bit_in(1); gap(); gap(); bit_in(1); gap();
    push(1, 1, 0, 8'd1, 2'd2);
    bit_in(0);
    chk("gap_done_beats_to", 32'(state), 2);
    step();

    // Same gaps with window 5: window advances through gaps and expires first
    cfg(8'b110, 4'd3, 8'd1, 16'd5);
    start_run();
    bit_in(1); gap(); gap(); bit_in(1);
    push(0, 0, 1, 8'd0, 2'd3);
    gap();
    chk("gap_window_to", 32'(state), 3);
    step();

    // cfg_load while ARMED is ignored
    cfg(8'b110, 4'd3, 8'd1, 16'd0);
    start_run();
    cfg_pattern = 8'b011; cfg_load = 1'b1; step(); cfg_load = 1'b0;
    bit_in(1); bit_in(1);
    push(1, 1, 0, 8'd1, 2'd2);
    bit_in(0);
    chk("armed_load_ignored", 32'(state), 2);
    step();

    // abort with completing bit
    cfg(8'b110, 4'd3, 8'd1, 16'd0);
    start_run();
    bit_in(1); bit_in(1);
    in_valid = 1'b1; in_sig = 1'b0; abort = 1'b1;
    step();
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_idle", 32'(state), 0);
    chk("abort_busy", 32'(busy), 0);

    // invalid configs
    cfg(8'b110, 4'd0, 8'd1, 16'd0);
    start_run();
    chk("len0_idle", 32'(state), 0);
    cfg(8'b110, 4'd3, 8'd0, 16'd0);
    start_run();
    chk("thr0_idle", 32'(state), 0);

    // start + abort in IDLE
    cfg(8'b110, 4'd3, 8'd1, 16'd0);
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(state), 0);

    // cfg_load + start together: new config used by this run
    cfg(8'b110, 4'd0, 8'd1, 16'd0);
    cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_threshold = 8'd1;
    cfg_load = 1'b1; start = 1'b1; step(); cfg_load = 1'b0; start = 1'b0;
    chk("load_start_armed", 32'(state), 1);
    bit_in(1);
    push(1, 1, 0, 8'd1, 2'd2);
    bit_in(1);
    chk("load_start_done", 32'(state), 2);
    step();

    // reset mid-run with match_count=1
    cfg(8'b110, 4'd3, 8'd2, 16'd0);
    start_run();
    bit_in(1); bit_in(1);
    push(1, 0, 0, 8'd1, 2'd1);
    bit_in(0);
    chk("pre_rst_count", 32'(match_count), 1);
    bit_in(1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_count", 32'(match_count), 0);
    chk("mid_rst_pulses", 32'({pattern_found, done, timeout}), 0);
    #3 rst = 1'b1;
    step(); step();
    chk("post_rst_idle", 32'(state), 0);
    start_run();
    chk("post_rst_cfg_cleared", 32'(state), 0);

    step(); step(); step();
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_check_ctrl.md
Name: seq_check_ctrl

Overview:
- Programmable serial-pattern detection controller. It holds the pattern configuration, arms and disarms detection, counts matches against a threshold, and enforces an observation window.
- Sits between a register/host interface and the serial input stream. It replaces fixed-pattern detectors (e.g. hard-wired "110").
- Sequences each detection run IDLE -> ARMED -> DONE/TIMEOUT -> IDLE and reports status.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, 4, width of cfg_len; must hold the value PAT_W.
- CNT_W, 8, width of the match counter and threshold.
- WIN_W, 16, width of the window counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cfg_load  in  1  latch cfg_* inputs; honoured only in IDLE.
- cfg_pattern  in  PAT_W  pattern; bit [cfg_len-1] is the oldest/first bit, bit [0] the newest/last.
- cfg_len  in  LEN_W  pattern length; legal range 1..PAT_W.
- cfg_threshold  in  CNT_W  matches required for DONE; legal range >= 1.
- cfg_window  in  WIN_W  ARMED-cycle limit; 0 = no limit.
- start  in  1  arm a run; honoured only in IDLE with a valid config.
- abort  in  1  force IDLE from any state.
- in_valid  in  1  in_sig is sampled only when this is high.
- in_sig  in  1  serial data bit.
- busy  out  1  high in ARMED.
- pattern_found  out  1  one-cycle pulse per match.
- match_count  out  CNT_W  matches in current/last run.
- done  out  1  one-cycle pulse when threshold reached.
- timeout  out  1  one-cycle pulse when window expires.
- state  out  2  IDLE=0, ARMED=1, DONE=2, TIMEOUT=3.

Behaviour:
- Reset (rst=0):
  - All outputs are 0 and state=IDLE.
  - Config registers are 0, the history shift register is 0, and the fill and window counters are 0.
- Config:
  - A valid config requires cfg_len in 1..PAT_W and cfg_threshold >= 1.
  - cfg_load outside IDLE is ignored.
  - start with an invalid config is ignored; state stays IDLE.
- IDLE -> ARMED on start:
  - Clears the history, the fill counter, the window counter and match_count.
  - busy=1 from the next cycle.
- ARMED, each cycle with in_valid=1:
  - history <= {history[PAT_W-2:0], in_sig}.
  - fill counter increments, saturating at PAT_W.
- Match condition: fill >= cfg_len and the low cfg_len bits of the updated history equal the low cfg_len bits of cfg_pattern.
- Match handling:
  - Outputs are registered, so pattern_found=1 in the cycle after the completing bit is sampled.
  - match_count increments in that same cycle.
  - Overlapping matches count (default build).
- Threshold:
  - The match that makes match_count == cfg_threshold moves the FSM to DONE.
  - done=1 and pattern_found=1 in the same cycle.
- Window:
  - The window counter increments on every ARMED cycle, including cycles with in_valid=0.
  - If cfg_window != 0 and the counter reaches cfg_window without DONE, the FSM goes to TIMEOUT and timeout=1.
- Cycles with in_valid=0: no shift, no match, and the fill counter holds.
- DONE and TIMEOUT last exactly one cycle, then return to IDLE.
  - match_count holds its final value until the next start.
  - busy=0 in DONE, TIMEOUT and IDLE.
- Simultaneous events:
  - abort beats everything; in the next cycle the FSM is IDLE and no done/timeout/pattern_found pulse is issued for that cycle.
  - A threshold match beats window expiry in the same cycle: DONE is entered, no timeout.
  - start together with abort in IDLE: abort wins and the FSM stays IDLE.
  - cfg_load together with start in IDLE: the new config is latched and used by this run.
- Asynchronous reset mid-run: immediate return to reset values; no pulses issued.
- match_count never wraps, because the run ends at threshold.

Optional Feature:
- Macro SEQ_CHECK_NOOVERLAP_EN.
- Defined: each match clears the history and the fill counter, so the next match needs cfg_len fresh bits (non-overlapping detection).
- Undefined: history is retained after a match and overlapping matches count.

Test Plan:
- Basic "110":
  - Stimulus: load pattern=3'b110, len=3, threshold=1, window=0; start; in_valid=1 with in_sig 1,1,0.
  - Required: pattern_found=1 and done=1 one cycle after the '0' is sampled; match_count=1; state DONE for 1 cycle, then IDLE.
- Overlap:
  - Stimulus: pattern=3'b101, len=3, threshold=2; bits 1,0,1,0,1.
  - Default build: matches after bits 3 and 5, match_count=2, done.
  - With SEQ_CHECK_NOOVERLAP_EN: one match only, match_count=1, busy stays 1.
- Timeout:
  - Stimulus: pattern=3'b110, threshold=1, window=10; constant in_sig=0.
  - Required: timeout pulses after the 10th ARMED cycle; state TIMEOUT, then IDLE; match_count=0; done never asserts.
- in_valid gaps:
  - Stimulus: bits 1,1,0 with in_valid=0 cycles interleaved between them.
  - Required: exactly one match, no spurious matches; the window counter still advances during the gaps.
- Control boundaries:
  - cfg_load with a new pattern while ARMED: ignored; the old pattern still matches.
  - abort raised the same cycle as a completing bit: no pattern_found, FSM IDLE.
  - start with len=0: state stays IDLE.
- Reset mid-run:
  - Stimulus: rst=0 for part of a cycle while ARMED with match_count=1.
  - Required: all outputs 0 immediately; after release the FSM stays IDLE until start.
